// File: rtl/gpio_pkg.sv
// Shared constants for the APB GPIO controller.
// Register byte offsets and bus widths.
package gpio_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 8;

    localparam logic [7:0] OFS_DATAIN  = 8'h00;
    localparam logic [7:0] OFS_DATAOUT = 8'h04;
    localparam logic [7:0] OFS_DIR     = 8'h08;
    localparam logic [7:0] OFS_PU      = 8'h0C;
    localparam logic [7:0] OFS_PD      = 8'h10;
    localparam logic [7:0] OFS_IE      = 8'h14;
    localparam logic [7:0] OFS_EDGE    = 8'h18;
    localparam logic [7:0] OFS_IS      = 8'h1C;

endpackage

// File: rtl/apb_gpio_ctrl_if.sv
// APB bus bundle between fabric (master) and GPIO block (slave).
// Zero-wait-state slave: PREADY/PSLVERR are slave outputs.
interface apb_gpio_ctrl_if;
    import gpio_pkg::*;

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/gpio_sync.sv
// N-bit two-flop synchronizer for asynchronous pad inputs.
// Async active-low reset clears both stages.
module gpio_sync #(
    parameter int N = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] meta_q;
    logic [N-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB register block for GPIO: data/dir/pull registers and
// synchronized inputs with sticky edge interrupts.
module apb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int N = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_gpio_ctrl_if.slave    apb,
    input  logic [N-1:0]      WGPIODIN,
    output logic [N-1:0]      WGPIODOUT,
    output logic [N-1:0]      WGPIODIR,
    output logic [N-1:0]      WGPIOPU,
    output logic [N-1:0]      WGPIOPD,
    output logic              IRQ
);

    logic [N-1:0] dout_q, dout_d;
    logic [N-1:0] dir_q, dir_d;
    logic [N-1:0] pu_q, pu_d;
    logic [N-1:0] pd_q, pd_d;
    logic [N-1:0] ie_q, ie_d;
    logic [N-1:0] edge_q, edge_d;
    logic [N-1:0] is_q, is_d;
    logic [N-1:0] prev_q;
    logic [N-1:0] sync;
    logic [N-1:0] evt;
    logic [N-1:0] is_clr;
    logic [N-1:0] wdata;
    logic [7:0]   addr;
    logic         wr_en;
    logic [DATA_W-1:0] rdata;
    logic         unused_bits;

    gpio_sync #(.N(N)) u_sync (
        .clk_i  (PCLK),
        .rst_ni (PRESETn),
        .d_i    (WGPIODIN),
        .q_o    (sync)
    );

    assign addr  = {apb.PADDR[7:2], 2'b00};
    assign wdata = apb.PWDATA[N-1:0];
    assign wr_en = apb.PSEL & apb.PENABLE & apb.PWRITE;
    assign unused_bits = ^{apb.PADDR[1:0], apb.PWDATA};

    // Edge polarity comes from data history only, so EDGE
    // changes on a static pin never fire.
    assign evt = (edge_q & sync & ~prev_q)
               | (~edge_q & ~sync & prev_q);

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        pu_d   = pu_q;
        pd_d   = pd_q;
        ie_d   = ie_q;
        edge_d = edge_q;
        is_clr = '0;
        if (wr_en) begin
            unique case (1'b1)
                (addr == OFS_DATAOUT): dout_d = wdata;
                (addr == OFS_DIR):     dir_d  = wdata;
                (addr == OFS_PU):      pu_d   = wdata;
                (addr == OFS_PD):      pd_d   = wdata;
                (addr == OFS_IE):      ie_d   = wdata;
                (addr == OFS_EDGE):    edge_d = wdata;
                (addr == OFS_IS):      is_clr = wdata;
                default: ;
            endcase
        end
        // New events win over a same-cycle W1C.
        is_d = (is_q & ~is_clr) | (evt & ie_q);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dout_q <= '0;
            dir_q  <= '0;
            pu_q   <= '0;
            pd_q   <= '0;
            ie_q   <= '0;
            edge_q <= '0;
            is_q   <= '0;
            prev_q <= '0;
        end else begin
            dout_q <= dout_d;
            dir_q  <= dir_d;
            pu_q   <= pu_d;
            pd_q   <= pd_d;
            ie_q   <= ie_d;
            edge_q <= edge_d;
            is_q   <= is_d;
            prev_q <= sync;
        end
    end

    always_comb begin
        rdata = '0;
        if (apb.PSEL && !apb.PWRITE) begin
            unique case (1'b1)
                (addr == OFS_DATAIN):  rdata[N-1:0] = sync;
                (addr == OFS_DATAOUT): rdata[N-1:0] = dout_q;
                (addr == OFS_DIR):     rdata[N-1:0] = dir_q;
                (addr == OFS_PU):      rdata[N-1:0] = pu_q;
                (addr == OFS_PD):      rdata[N-1:0] = pd_q;
                (addr == OFS_IE):      rdata[N-1:0] = ie_q;
                (addr == OFS_EDGE):    rdata[N-1:0] = edge_q;
                (addr == OFS_IS):      rdata[N-1:0] = is_q;
                default: ;
            endcase
        end
    end

    assign apb.PRDATA  = rdata;
    assign apb.PREADY  = 1'b1;
    assign apb.PSLVERR = 1'b0;

    assign WGPIODOUT = dout_q;
    assign WGPIODIR  = dir_q;
    assign WGPIOPU   = pu_q;
    assign WGPIOPD   = pd_q;
    assign IRQ       = |(is_q & ie_q);

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Scoreboard bench for apb_gpio_ctrl: directed scenarios then
// random APB traffic and pin activity against a history model.
module tb_apb_gpio_ctrl;
    import gpio_pkg::*;

    localparam int N = 16;

    logic         PCLK = 1'b0;
    logic         PRESETn = 1'b0;
    logic [N-1:0] din = '0;
    logic [N-1:0] dout, dir, pu, pd;
    logic         irq;

    apb_gpio_ctrl_if bus();

    apb_gpio_ctrl #(.N(N)) dut (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .apb       (bus),
        .WGPIODIN  (din),
        .WGPIODOUT (dout),
        .WGPIODIR  (dir),
        .WGPIOPU   (pu),
        .WGPIOPD   (pd),
        .IRQ       (irq)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    // Model: register file by word index (1..7), and pin
    // samples h[0] newest; DATAIN shows the sample one edge
    // older, and an event compares the two older samples.
    logic [N-1:0] m_reg [8];
    logic [N-1:0] h [3];
    bit           port_chk = 0;

    task automatic chk(string name, logic [31:0] act,
                       logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        for (int i = 0; i < 3; i++) h[i] = '0;
    endtask

    function automatic logic [31:0] m_read(logic [7:0] a);
        logic [31:0] r;
        r = '0;
        if (a[7:5] == 3'd0) begin
            if (a[4:2] == 3'd0) r[N-1:0] = h[1];
            else r[N-1:0] = m_reg[a[4:2]];
        end
        return r;
    endfunction

    task automatic check_ports();
        chk("dout", 32'(dout), 32'(m_reg[1]));
        chk("dir",  32'(dir),  32'(m_reg[2]));
        chk("pu",   32'(pu),   32'(m_reg[3]));
        chk("pd",   32'(pd),   32'(m_reg[4]));
        chk("irq",  32'(irq),  32'(|(m_reg[7] & m_reg[5])));
    endtask

    task automatic cycle();
        logic [N-1:0] pin, wd, evt, clr, ie_old, ed_old;
        logic [7:0]   a;
        bit           wr;
        pin = din;
        wr  = bus.PSEL && bus.PENABLE && bus.PWRITE;
        a   = bus.PADDR;
        wd  = bus.PWDATA[N-1:0];
        @(posedge PCLK);
        if (!PRESETn) begin
            model_reset();
        end else begin
            ie_old = m_reg[5];
            ed_old = m_reg[6];
            evt = (ed_old & h[1] & ~h[2])
                | (~ed_old & ~h[1] & h[2]);
            clr = '0;
            if (wr && a[7:5] == 3'd0 && a[4:2] != 3'd0) begin
                if (a[4:2] == 3'd7) clr = wd;
                else m_reg[a[4:2]] = wd;
            end
            m_reg[7] = (m_reg[7] & ~clr) | (evt & ie_old);
            h[2] = h[1];
            h[1] = h[0];
            h[0] = pin;
        end
        #1;
        if (port_chk) check_ports();
    endtask

    task automatic bus_idle();
        bus.PSEL    = 1'b0;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
    endtask

    task automatic apb_wr(logic [7:0] a, logic [31:0] d);
        bus.PSEL    = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = a;
        bus.PWDATA  = d;
        bus.PENABLE = 1'b0;
        cycle();
        bus.PENABLE = 1'b1;
        cycle();
        bus_idle();
    endtask

    task automatic apb_rd_x(string name, logic [7:0] a,
                            bit use_model, logic [31:0] exp);
        exp_t e;
        bus.PSEL    = 1'b1;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = a;
        bus.PENABLE = 1'b0;
        cycle();
        bus.PENABLE = 1'b1;
        e.name = name;
        e.exp  = use_model ? m_read(a) : exp;
        sb.push_back(e);
        cycle();
        bus_idle();
    endtask

    task automatic rd_exp(string name, logic [7:0] a,
                          logic [31:0] exp);
        apb_rd_x(name, a, 1'b0, exp);
    endtask

    task automatic rd_mod(string name, logic [7:0] a);
        apb_rd_x(name, a, 1'b1, '0);
    endtask

    // Monitor: every completed read access pops one entry.
    always @(negedge PCLK) begin
        exp_t e;
        if (PRESETn && bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got %h expected none",
                         bus.PRDATA);
            end else begin
                e = sb.pop_front();
                chk(e.name, bus.PRDATA, e.exp);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] a;
        int r;
        bus_idle();
        model_reset();
        repeat (2) cycle();
        PRESETn = 1'b1;
        port_chk = 1;
        cycle();
        chk("rst_irq", 32'(irq), 32'd0);
        rd_exp("rst_dout", OFS_DATAOUT, 32'h0);
        rd_exp("rst_is", OFS_IS, 32'h0);

        apb_wr(OFS_DIR, 32'h0000_00FF);
        chk("dir_port", 32'(dir), 32'h00FF);
        apb_wr(OFS_DATAOUT, 32'hFFFF_A5A5);
        chk("dout_port", 32'(dout), 32'hA5A5);
        apb_wr(OFS_PU, 32'h0000_0F00);
        apb_wr(OFS_PD, 32'h0000_00F0);
        chk("pu_port", 32'(pu), 32'h0F00);
        chk("pd_port", 32'(pd), 32'h00F0);
        apb_wr(8'h24, 32'hFFFF_FFFF);
        apb_wr(OFS_DATAIN, 32'hFFFF_FFFF);
        rd_exp("rb_dir", OFS_DIR, 32'h00FF);
        rd_exp("rb_dout", OFS_DATAOUT, 32'hA5A5);
        rd_exp("rb_pu", OFS_PU, 32'h0F00);
        rd_exp("rb_pd", OFS_PD, 32'h00F0);
        rd_exp("rb_oob", 8'h24, 32'h0);
        rd_exp("rb_datain", OFS_DATAIN, 32'h0);

        din = 16'h1234;
        rd_exp("sync_early", OFS_DATAIN, 32'h0);
        rd_exp("sync_late", OFS_DATAIN, 32'h1234);
        din = '0;
        repeat (3) cycle();

        apb_wr(OFS_IE, 32'h3);
        apb_wr(OFS_EDGE, 32'h1);
        din = 16'h0007;
        repeat (3) cycle();
        chk("edge_irq", 32'(irq), 32'd1);
        rd_exp("edge_is1", OFS_IS, 32'h1);
        din = 16'h0005;
        repeat (3) cycle();
        rd_exp("edge_is3", OFS_IS, 32'h3);

        din = 16'h0004;
        repeat (3) cycle();
        din = 16'h0005;
        cycle();
        apb_wr(OFS_IS, 32'h1);
        chk("race_irq", 32'(irq), 32'd1);
        rd_exp("race_is", OFS_IS, 32'h3);
        apb_wr(OFS_IS, 32'h3);
        chk("clr_irq", 32'(irq), 32'd0);
        rd_exp("clr_is", OFS_IS, 32'h0);

        apb_wr(OFS_IE, 32'h7);
        din = 16'h0001;
        repeat (3) cycle();
        rd_exp("mask_is", OFS_IS, 32'h4);
        apb_wr(OFS_IE, 32'h3);
        chk("mask_irq0", 32'(irq), 32'd0);
        rd_exp("mask_is_kept", OFS_IS, 32'h4);
        apb_wr(OFS_IE, 32'h7);
        chk("mask_irq1", 32'(irq), 32'd1);

        bus.PSEL    = 1'b1;
        bus.PWRITE  = 1'b1;
        bus.PADDR   = OFS_DATAOUT;
        bus.PWDATA  = 32'hFFFF;
        bus.PENABLE = 1'b0;
        cycle();
        bus.PENABLE = 1'b1;
        #2;
        PRESETn = 1'b0;
        model_reset();
        #1;
        chk("arst_dout", 32'(dout), 32'h0);
        chk("arst_dir", 32'(dir), 32'h0);
        chk("arst_irq", 32'(irq), 32'd0);
        cycle();
        bus_idle();
        cycle();
        PRESETn = 1'b1;
        for (int i = 1; i < 8; i++) begin
            a = 8'(i * 4);
            rd_exp("arst_rb", a, 32'h0);
        end
        rd_mod("arst_datain", OFS_DATAIN);

        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) == 0) din = N'($urandom);
            r = $urandom_range(0, 9);
            a = 8'($urandom_range(0, 9) * 4)
              | 8'($urandom_range(0, 3));
            if (r < 4) apb_wr(a, $urandom);
            else if (r < 8) rd_mod("rnd_rd", a);
            else cycle();
        end
        repeat (4) cycle();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
